// File: rtl/tv_checker.sv
// -----------------------------------------------------------------------------
// tv_checker
//
// Self-checking test-vector engine. A vector memory, loaded over a simple write
// port, holds {valid, stim, exp, mask} words. On start the engine plays each
// valid vector's stimulus into an external DUT, and compares the DUT response
// against the masked expected value LAT+1 cycles after the stimulus register
// updates. It reports the mismatch count, the number of compares and the index
// of the first failing vector.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   wr_en/wr_addr/wr_data  vector write port (IDLE/DONE only)
//                  wr_data = {valid, stim[IN_W], exp[OUT_W], mask[OUT_W]}
//   start          begin a run (IDLE/DONE only)
//   stop_on_err    sampled with start; halt at the first mismatch
//   stim           registered stimulus to the DUT
//   dut_out        DUT response
//   busy           running or draining the compare pipe
//   done           results are final
//   pass           done with zero mismatches
//   err_count      saturating mismatch count
//   tests_run      number of vectors compared
//   first_err_idx  index of the first mismatching vector
//   first_err_vld  first_err_idx is meaningful
// -----------------------------------------------------------------------------
module tv_checker #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 1,
  parameter int DEPTH = 16,
  parameter int LAT   = 0,
  parameter int ERR_W = 8,
  localparam int VW   = 1 + IN_W + 2 * OUT_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VW-1:0]    wr_data,
  input  logic             start,
  input  logic             stop_on_err,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [CW-1:0]    tests_run,
  output logic [AW-1:0]    first_err_idx,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CW-1:0]     tr_q, tr_d;
  logic [AW-1:0]     fidx_q, fidx_d;
  logic              fvld_q, fvld_d;
  logic              stop_q, stop_d;

  // Compare pipe: stage 0 is loaded alongside stim, stage LAT is compared.
  logic [LAT:0]      pv_q, pv_d;
  logic [OUT_W-1:0]  pexp_q  [LAT+1];
  logic [OUT_W-1:0]  pexp_d  [LAT+1];
  logic [OUT_W-1:0]  pmask_q [LAT+1];
  logic [OUT_W-1:0]  pmask_d [LAT+1];
  logic [AW-1:0]     pidx_q  [LAT+1];
  logic [AW-1:0]     pidx_d  [LAT+1];

  logic [VW-1:0]     mem_q [DEPTH];
  logic              mem_we;

  logic [VW-1:0]     cur_vec;
  logic              cur_valid;
  logic [IN_W-1:0]   cur_stim;
  logic [OUT_W-1:0]  cur_exp;
  logic [OUT_W-1:0]  cur_mask;
  logic              at_end;
  logic              cmp_fire;
  logic              mismatch;
  logic              halt;

  // Vector fetch; idx can equal DEPTH once every entry has been issued.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    cur_vec = '0;
    at_end  = (idx_q == CW'(DEPTH));
    if (!at_end) cur_vec = mem_q[idx_q[AW-1:0]];
  end

  assign cur_valid = cur_vec[VW-1];
  assign cur_stim  = cur_vec[VW-2 -: IN_W];
  assign cur_exp   = cur_vec[2*OUT_W-1 -: OUT_W];
  assign cur_mask  = cur_vec[OUT_W-1:0];

  assign cmp_fire = pv_q[LAT] && (state_q == S_RUN || state_q == S_DRAIN);
  assign mismatch = cmp_fire && (|((dut_out ^ pexp_q[LAT]) & pmask_q[LAT]));
  assign halt     = mismatch && stop_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    err_d   = err_q;
    tr_d    = tr_q;
    fidx_d  = fidx_q;
    fvld_d  = fvld_q;
    stop_d  = stop_q;
    pv_d    = pv_q;
    pexp_d  = pexp_q;
    pmask_d = pmask_q;
    pidx_d  = pidx_q;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        mem_we = wr_en && (32'(wr_addr) < DEPTH);
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          err_d   = '0;
          tr_d    = '0;
          fidx_d  = '0;
          fvld_d  = 1'b0;
          stop_d  = stop_on_err;
          pv_d    = '0;
        end
      end

      S_RUN, S_DRAIN: begin
        for (int i = 1; i <= LAT; i++) begin
          pv_d[i]    = pv_q[i-1];
          pexp_d[i]  = pexp_q[i-1];
          pmask_d[i] = pmask_q[i-1];
          pidx_d[i]  = pidx_q[i-1];
        end
        pv_d[0] = 1'b0;

        if (cmp_fire) begin
          tr_d = tr_q + 1'b1;
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fidx_d = pidx_q[LAT];
            end
          end
        end

        if (halt) begin
          // Abandon everything still in flight; it is neither compared nor counted.
          state_d = S_DONE;
          pv_d    = '0;
        end else if (state_q == S_RUN) begin
          if (at_end || !cur_valid) begin
            state_d = S_DRAIN;
          end else begin
            stim_d     = cur_stim;
            pv_d[0]    = 1'b1;
            pexp_d[0]  = cur_exp;
            pmask_d[0] = cur_mask;
            pidx_d[0]  = idx_q[AW-1:0];
            idx_d      = idx_q + 1'b1;
          end
        end else if (pv_q == '0) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low, so it is tested inside the
    // clocked branch rather than in the sensitivity list; state updates use
    // non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      tr_q    <= '0;
      fidx_q  <= '0;
      fvld_q  <= 1'b0;
      stop_q  <= 1'b0;
      pv_q    <= '0;
      pexp_q  <= '{default: '0};
      pmask_q <= '{default: '0};
      pidx_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      tr_q    <= tr_d;
      fidx_q  <= fidx_d;
      fvld_q  <= fvld_d;
      stop_q  <= stop_d;
      pv_q    <= pv_d;
      pexp_q  <= pexp_d;
      pmask_q <= pmask_d;
      pidx_q  <= pidx_d;
    end
  end

  // NOTE: the vector memory has no reset; its contents must survive a reset so
  // an interrupted run can be repeated, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_addr] <= wr_data;
  end

  assign stim          = stim_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == '0);
  assign err_count     = err_q;
  assign tests_run     = tr_q;
  assign first_err_idx = fidx_q;
  assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_tv_checker.sv
// -----------------------------------------------------------------------------
// tb_tv_checker
//
// Two checker instances: u0 (DEPTH=8, LAT=0, ERR_W=2) drives a combinational
// 4-bit inverter, u1 (DEPTH=16, LAT=2, ERR_W=8) drives a two-register inverter.
// A reference model computes every compare and the final result from the vector
// contents; a monitor pops and checks them as the DUT reports.
// -----------------------------------------------------------------------------
module tb_tv_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [12:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;

  always #5 clk = ~clk;

  // u0 signals
  logic [3:0] stim0, dout0;
  logic       busy0, done0, pass0, fev0;
  logic [1:0] err0;
  logic [3:0] tr0;
  logic [2:0] fidx0;
  // u1 signals
  logic [3:0] stim1, dout1, r1a, r1b;
  logic       busy1, done1, pass1, fev1;
  logic [7:0] err1;
  logic [4:0] tr1;
  logic [3:0] fidx1;

  assign dout0 = ~stim0;
  always @(posedge clk) begin
    r1a <= ~stim1;
    r1b <= r1a;
  end
  assign dout1 = r1b;

  tv_checker #(.IN_W(4), .OUT_W(4), .DEPTH(8), .LAT(0), .ERR_W(2)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en && !sel), .wr_addr(wr_addr[2:0]),
    .wr_data(wr_data), .start(start && !sel), .stop_on_err(stop),
    .stim(stim0), .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .tests_run(tr0), .first_err_idx(fidx0), .first_err_vld(fev0)
  );

  tv_checker #(.IN_W(4), .OUT_W(4), .DEPTH(16), .LAT(2), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en && sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start && sel), .stop_on_err(stop),
    .stim(stim1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .tests_run(tr1), .first_err_idx(fidx1), .first_err_vld(fev1)
  );

  // Selected-instance view, zero extended.
  logic [3:0] stim_m;
  logic       busy_m, done_m, pass_m, fev_m;
  int         err_m, tr_m, fidx_m;
  always_comb begin
    stim_m = sel ? stim1 : stim0;
    busy_m = sel ? busy1 : busy0;
    done_m = sel ? done1 : done0;
    pass_m = sel ? pass1 : pass0;
    fev_m  = sel ? fev1  : fev0;
    err_m  = sel ? int'(err1)  : int'(err0);
    tr_m   = sel ? int'(tr1)   : int'(tr0);
    fidx_m = sel ? int'(fidx1) : int'(fidx0);
  end

  typedef struct {int tr; int err; int fev; int fidx;} cmp_t;
  typedef struct {int tr; int err; int fev; int fidx; int pass; int edge_n;} fin_t;

  cmp_t cmp_q[$];
  fin_t fin_q[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [12:0] vmem [2][16];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic prev_sel = 1'b0;
  int   prev_tr = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (sel == prev_sel && rst) begin
      if (tr_m != prev_tr && tr_m != 0) begin
        if (cmp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_compare: got tests_run %0d with nothing expected", tr_m);
        end else begin
          cmp_t c;
          c = cmp_q.pop_front();
          check("cmp_tests_run", tr_m, c.tr);
          check("cmp_err_count", err_m, c.err);
          check("cmp_first_vld", int'(fev_m), c.fev);
          check("cmp_first_idx", fidx_m, c.fidx);
        end
      end
      if (done_m && !prev_done) begin
        if (fin_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done rose at edge %0d with nothing expected", edge_n);
        end else begin
          fin_t f;
          f = fin_q.pop_front();
          check("fin_tests_run", tr_m, f.tr);
          check("fin_err_count", err_m, f.err);
          check("fin_first_vld", int'(fev_m), f.fev);
          check("fin_first_idx", fidx_m, f.fidx);
          check("fin_pass", int'(pass_m), f.pass);
          check("fin_busy", int'(busy_m), 0);
          if (f.edge_n >= 0) check("fin_done_edge", edge_n, f.edge_n);
        end
      end
    end
    prev_sel  = sel;
    prev_tr   = tr_m;
    prev_done = done_m;
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic [12:0] mk(input logic v, input logic [3:0] s,
                                     input logic [3:0] e, input logic [3:0] m);
    return {v, s, e, m};
  endfunction

  task automatic load(input int s, input int skip);
    int depth;
    depth = s ? 16 : 8;
    @(negedge clk);
    sel = s[0];
    for (int a = 0; a < depth; a++) begin
      if (a != skip) begin
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = vmem[s][a];
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, int'(busy_m), 0);
    check({tag, "_done"}, int'(done_m), 0);
    check({tag, "_err"}, err_m, 0);
    check({tag, "_tests_run"}, tr_m, 0);
    check({tag, "_first_vld"}, int'(fev_m), 0);
    check({tag, "_stim"}, int'(stim_m), 0);
  endtask

  // Model the run, start it (optionally writing entry ws in the start cycle),
  // poke an ignored write while busy, then wait for the monitor to consume it.
  task automatic run(input int s, input bit stop_e, input int ws);
    int depth, lat, emax, n, e0, t;
    int tr, err, fev, fidx;
    bit halted;
    logic [3:0] st, ex, mk4, resp;
    fin_t f;
    depth = s ? 16 : 8;
    lat   = s ? 2 : 0;
    emax  = s ? 255 : 3;
    n = 0;
    while (n < depth && vmem[s][n][12]) n++;
    tr = 0; err = 0; fev = 0; fidx = 0; halted = 1'b0;
    for (int k = 0; k < n; k++) begin
      st = vmem[s][k][11:8]; ex = vmem[s][k][7:4]; mk4 = vmem[s][k][3:0];
      resp = ~st;
      tr++;
      if (((resp ^ ex) & mk4) != 4'h0) begin
        if (err < emax) err++;
        if (fev == 0) begin fev = 1; fidx = k; end
        cmp_q.push_back('{tr, err, fev, fidx});
        if (stop_e) begin halted = 1'b1; break; end
      end else begin
        cmp_q.push_back('{tr, err, fev, fidx});
      end
    end
    @(negedge clk);
    sel = s[0]; stop = stop_e; start = 1'b1;
    if (ws >= 0) begin
      wr_en = 1'b1; wr_addr = ws[3:0]; wr_data = vmem[s][ws];
    end
    e0 = edge_n + 1;
    f.tr = tr; f.err = err; f.fev = fev; f.fidx = fidx; f.pass = (err == 0);
    f.edge_n = halted ? -1 : (n == 0 ? e0 + 2 : e0 + n + lat + 2);
    fin_q.push_back(f);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~vmem[s][0];
    @(negedge clk);
    wr_en = 1'b0;
    t = 0;
    while (fin_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (fin_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: done not seen within %0d cycles", t);
      fin_q.delete();
    end
    check("leftover_compares", cmp_q.size(), 0);
    cmp_q.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [3:0] s4, m4;
    repeat (3) @(negedge clk);
    sel = 1'b0; @(negedge clk); check_zero("reset_u0");
    sel = 1'b1; @(negedge clk); check_zero("reset_u1");
    rst = 1'b1;

    // u0: five good vectors with random masks; entry 0 written with start.
    for (int a = 0; a < 8; a++) begin
      s4 = 4'($urandom); m4 = 4'($urandom);
      vmem[0][a] = mk(a < 5, s4, ~s4, m4);
    end
    load(0, 0);
    run(0, 1'b0, 0);

    // u0: all eight wrong in every bit -> error count saturates at 3.
    for (int a = 0; a < 8; a++) begin
      s4 = 4'($urandom);
      vmem[0][a] = mk(1'b1, s4, s4, 4'hF);
    end
    load(0, -1);
    run(0, 1'b0, -1);

    // u0: wrong expectations hidden by mask=0.
    for (int a = 0; a < 8; a++) begin
      s4 = 4'($urandom);
      vmem[0][a] = mk(a < 4, s4, s4, 4'h0);
    end
    load(0, -1);
    run(0, 1'b0, -1);

    // u0: mismatches at 1 and 3, halting at the first.
    for (int a = 0; a < 8; a++) begin
      s4 = 4'($urandom);
      vmem[0][a] = mk(a < 4, s4, (a == 1 || a == 3) ? s4 : ~s4, 4'hF);
    end
    load(0, -1);
    run(0, 1'b1, -1);

    // u1: empty run.
    for (int a = 0; a < 16; a++) vmem[1][a] = mk(a != 0, 4'h5, 4'hA, 4'hF);
    load(1, -1);
    run(1, 1'b0, -1);

    // u1: randomized vector sets.
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < 16; a++) begin
        s4 = 4'($urandom); m4 = 4'($urandom);
        vmem[1][a] = mk($urandom_range(0, 15) != 0, s4,
                        ($urandom_range(0, 9) < 3) ? ~s4 ^ 4'($urandom) : ~s4, m4);
      end
      load(1, -1);
      run(1, 1'($urandom), -1);
    end

    // u1: reset two cycles after start, then rerun the unchanged memory.
    for (int a = 0; a < 16; a++) begin
      s4 = 4'($urandom);
      vmem[1][a] = mk(a < 6, s4, (a == 2) ? s4 : ~s4, 4'hF);
    end
    load(1, -1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); check_zero("midrun_reset_a");
    @(negedge clk); check_zero("midrun_reset_b");
    rst = 1'b1;
    run(1, 1'b0, -1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
